// File: rtl/ccr_unit_pkg.sv
// Shared condition-code definitions: flag bit positions, jump-select encodings
// and the default shadow-stack depth used by the ALU and the CCR unit.
package ccr_unit_pkg;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  localparam int FLAGS_W         = 4;
  localparam int STACK_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    SEL_Z = 2'b00,
    SEL_N = 2'b01,
    SEL_C = 2'b10,
    SEL_V = 2'b11
  } jmp_sel_e;

  // Maps a jump condition code to the CCR bit it tests.
  function automatic logic [1:0] sel_to_bit(input jmp_sel_e sel);
    logic [1:0] idx;
    case (sel)
      SEL_Z:   idx = 2'(FLAG_Z);
      SEL_N:   idx = 2'(FLAG_N);
      SEL_C:   idx = 2'(FLAG_C);
      default: idx = 2'(FLAG_V);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/ccr_unit_if.sv
// Request/response bundle between the core control path and the CCR unit.
interface ccr_unit_if;
  import ccr_unit_pkg::*;

  logic               flags_we;
  logic [FLAGS_W-1:0] flags_in;
  logic               jmp_valid;
  logic [1:0]         jmp_sel;
  logic               int_save;
  logic               rti_restore;
  logic [FLAGS_W-1:0] flags_out;
  logic               jmp_taken;
  logic               stack_full;
  logic               stack_empty;
  logic               err;

  modport master (
    output flags_we, flags_in, jmp_valid, jmp_sel, int_save, rti_restore,
    input  flags_out, jmp_taken, stack_full, stack_empty, err
  );

  modport slave (
    input  flags_we, flags_in, jmp_valid, jmp_sel, int_save, rti_restore,
    output flags_out, jmp_taken, stack_full, stack_empty, err
  );
endinterface

// File: rtl/ccr_unit_flag_stack.sv
// Parameterised LIFO holding saved CCR values for nested interrupts.
// Callers must not push when full or pop when empty.
module flag_stack #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] top,
  output logic              full,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]     cnt;
  logic [DATA_W-1:0] mem [0:(2**IW)-1];
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     top_idx;

  assign wr_idx  = IW'(cnt);
  assign top_idx = IW'(cnt - PW'(1));
  assign top     = mem[top_idx];
  assign full    = (cnt == PW'(DEPTH));
  assign empty   = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + PW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - PW'(1);
    end
  end

  // Entry contents carry no reset; they are only visible below the depth.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end
endmodule

// File: rtl/ccr_unit.sv
// Condition-code register with jump evaluation, flag clear on taken jump,
// and a shadow stack for interrupt entry/return with illegal-request flagging.
module ccr_unit
  import ccr_unit_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input logic        clk,
  input logic        rst,
  ccr_unit_if.slave  bus
);
  logic [FLAGS_W-1:0] ccr_p1;
  logic [FLAGS_W-1:0] ccr_next;
  logic [FLAGS_W-1:0] top;
  logic               err_p1;
  logic               full;
  logic               empty;
  logic [1:0]         sel_idx;
  logic               jmp_taken;
  logic               push_ok;
  logic               pop_ok;
  logic               illegal;

  assign sel_idx   = sel_to_bit(jmp_sel_e'(bus.jmp_sel));
  assign jmp_taken = bus.jmp_valid & ccr_p1[sel_idx];

  // Simultaneous save and restore cancels both stack operations.
  assign push_ok = bus.int_save & ~bus.rti_restore & ~full;
  assign pop_ok  = bus.rti_restore & ~bus.int_save & ~empty;
  assign illegal = (bus.int_save & bus.rti_restore)
                 | (bus.int_save & full)
                 | (bus.rti_restore & empty);

  always_comb begin
    ccr_next = ccr_p1;
    if (bus.flags_we) ccr_next = bus.flags_in;
    if (jmp_taken)    ccr_next[sel_idx] = 1'b0;
    if (pop_ok)       ccr_next = top;
  end

  flag_stack #(
    .DEPTH  (STACK_DEPTH),
    .DATA_W (FLAGS_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop_ok),
    .din   (ccr_p1),
    .top   (top),
    .full  (full),
    .empty (empty)
  );

  // Stage p1: architectural CCR and the error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_p1 <= '0;
      err_p1 <= 1'b0;
    end else begin
      ccr_p1 <= ccr_next;
      err_p1 <= illegal;
    end
  end

  assign bus.flags_out   = ccr_p1;
  assign bus.jmp_taken   = jmp_taken;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.err         = err_p1;
endmodule

// File: tb/tb_ccr_unit.sv
// Directed bench for ccr_unit: flag writes, jump clear, save/restore nesting,
// illegal requests and reset override, checked with immediate assertions.
module tb_ccr_unit;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  ccr_unit_if bus ();

  ccr_unit #(.STACK_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flags_we    = 1'b0;
    bus.flags_in    = 4'b0000;
    bus.jmp_valid   = 1'b0;
    bus.jmp_sel     = 2'b00;
    bus.int_save    = 1'b0;
    bus.rti_restore = 1'b0;
  endtask

  task automatic chk_stack(input string tag, input logic full, input logic empty);
    chk({tag, "_full"},  {3'b0, bus.stack_full},  {3'b0, full});
    chk({tag, "_empty"}, {3'b0, bus.stack_empty}, {3'b0, empty});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    step();
    step();
    chk("rst_flags", bus.flags_out, 4'b0000);
    chk("rst_err",   {3'b0, bus.err}, 4'b0000);
    chk_stack("rst", 1'b0, 1'b1);
    rst = 1'b0;

    // Write with no same-cycle bypass
    bus.flags_we = 1'b1; bus.flags_in = 4'b0101;
    #1;
    chk("wr_nobypass", bus.flags_out, 4'b0000);
    step(); idle();
    chk("wr_next", bus.flags_out, 4'b0101);

    // Jump tests on CCR=0100
    bus.flags_we = 1'b1; bus.flags_in = 4'b0100;
    step(); idle();
    bus.jmp_valid = 1'b1; bus.jmp_sel = 2'b00;
    #1;
    chk("jz_not_taken", {3'b0, bus.jmp_taken}, 4'b0000);
    step();
    chk("jz_ccr_keep", bus.flags_out, 4'b0100);
    bus.jmp_sel = 2'b10;
    #1;
    chk("jc_taken", {3'b0, bus.jmp_taken}, 4'b0001);
    step(); idle();
    chk("jc_clear", bus.flags_out, 4'b0000);
    #1;
    chk("jmp_invalid", {3'b0, bus.jmp_taken}, 4'b0000);

    // Jump clear overrides flags_in for the tested bit only
    bus.flags_we = 1'b1; bus.flags_in = 4'b1111;
    step(); idle();
    bus.jmp_valid = 1'b1; bus.jmp_sel = 2'b01;
    bus.flags_we = 1'b1; bus.flags_in = 4'b0110;
    #1;
    chk("jn_taken", {3'b0, bus.jmp_taken}, 4'b0001);
    step(); idle();
    chk("jn_clear_we", bus.flags_out, 4'b0100);
    bus.jmp_valid = 1'b1; bus.jmp_sel = 2'b11;
    #1;
    chk("jv_not_taken", {3'b0, bus.jmp_taken}, 4'b0000);
    idle();

    // Save / modify / restore
    bus.flags_we = 1'b1; bus.flags_in = 4'b1001;
    step(); idle();
    chk("sr_pre", bus.flags_out, 4'b1001);
    bus.int_save = 1'b1;
    step(); idle();
    chk("sr_saved", bus.flags_out, 4'b1001);
    chk_stack("sr_saved", 1'b0, 1'b0);
    bus.flags_we = 1'b1; bus.flags_in = 4'b0010;
    step(); idle();
    chk("sr_mod", bus.flags_out, 4'b0010);
    bus.rti_restore = 1'b1;
    bus.flags_we = 1'b1; bus.flags_in = 4'b0111;
    step(); idle();
    chk("sr_restored", bus.flags_out, 4'b1001);
    chk_stack("sr_restored", 1'b0, 1'b1);
    chk("sr_err", {3'b0, bus.err}, 4'b0000);

    // Fill the stack, overflow, then unwind in LIFO order
    bus.flags_we = 1'b1; bus.flags_in = 4'b0011;
    step(); idle();
    bus.int_save = 1'b1; bus.flags_we = 1'b1; bus.flags_in = 4'b1100;
    step(); idle();
    chk("ov_save1_ccr", bus.flags_out, 4'b1100);
    chk_stack("ov_save1", 1'b0, 1'b0);
    bus.int_save = 1'b1;
    step(); idle();
    chk_stack("ov_save2", 1'b1, 1'b0);
    chk("ov_save2_err", {3'b0, bus.err}, 4'b0000);
    bus.int_save = 1'b1; bus.flags_we = 1'b1; bus.flags_in = 4'b0001;
    step(); idle();
    chk("ov_err", {3'b0, bus.err}, 4'b0001);
    chk("ov_ccr", bus.flags_out, 4'b0001);
    chk_stack("ov", 1'b1, 1'b0);
    step();
    chk("ov_err_clear", {3'b0, bus.err}, 4'b0000);
    chk_stack("ov_hold", 1'b1, 1'b0);
    bus.rti_restore = 1'b1;
    step(); idle();
    chk("ov_rti1", bus.flags_out, 4'b1100);
    chk_stack("ov_rti1", 1'b0, 1'b0);
    bus.rti_restore = 1'b1;
    bus.flags_we = 1'b1; bus.flags_in = 4'b1111;
    bus.jmp_valid = 1'b1; bus.jmp_sel = 2'b11;
    step(); idle();
    chk("ov_rti2", bus.flags_out, 4'b0011);
    chk_stack("ov_rti2", 1'b0, 1'b1);
    chk("ov_rti2_err", {3'b0, bus.err}, 4'b0000);

    // Restore on empty stack
    bus.rti_restore = 1'b1; bus.flags_we = 1'b1; bus.flags_in = 4'b1000;
    step(); idle();
    chk("ue_ccr", bus.flags_out, 4'b1000);
    chk("ue_err", {3'b0, bus.err}, 4'b0001);
    chk_stack("ue", 1'b0, 1'b1);

    // Save and restore together with one entry held
    bus.flags_we = 1'b1; bus.flags_in = 4'b0110;
    step(); idle();
    chk("both_err_gap", {3'b0, bus.err}, 4'b0000);
    bus.int_save = 1'b1;
    step(); idle();
    bus.int_save = 1'b1; bus.rti_restore = 1'b1;
    bus.flags_we = 1'b1; bus.flags_in = 4'b0111;
    step(); idle();
    chk("both_err", {3'b0, bus.err}, 4'b0001);
    chk("both_ccr", bus.flags_out, 4'b0111);
    chk_stack("both", 1'b0, 1'b0);
    bus.rti_restore = 1'b1;
    step(); idle();
    chk("both_rti", bus.flags_out, 4'b0110);
    chk_stack("both_rti", 1'b0, 1'b1);

    // Reset overrides a concurrent write and save
    bus.int_save = 1'b1;
    step(); idle();
    chk_stack("pre_rst", 1'b0, 1'b0);
    rst = 1'b1;
    bus.flags_we = 1'b1; bus.flags_in = 4'b1111; bus.int_save = 1'b1;
    step(); idle();
    rst = 1'b0;
    chk("mrst_ccr", bus.flags_out, 4'b0000);
    chk("mrst_err", {3'b0, bus.err}, 4'b0000);
    chk_stack("mrst", 1'b0, 1'b1);
    bus.rti_restore = 1'b1;
    step(); idle();
    chk("mrst_rti_err", {3'b0, bus.err}, 4'b0001);
    chk("mrst_rti_ccr", bus.flags_out, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ccr_unit.md
CCR_UNIT -- requirements
Module: ccr_unit

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 2, giving the number of shadow-flag entries for nested interrupts.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port flags_we, input, 1 bit: the ALU result flags are to be written this cycle.
REQ-005 SHALL have port flags_in, input, 4 bits: ALU new flags {V,C,N,Z} (bit3=V, bit2=C, bit1=N, bit0=Z).
REQ-006 SHALL have port jmp_valid, input, 1 bit: a conditional jump is being evaluated this cycle.
REQ-007 SHALL have port jmp_sel, input, 2 bits: condition to test (00=Z, 01=N, 10=C, 11=V).
REQ-008 SHALL have port int_save, input, 1 bit: push the current CCR onto the shadow stack (interrupt entry).
REQ-009 SHALL have port rti_restore, input, 1 bit: pop the shadow stack into the CCR (RTI).
REQ-010 SHALL have port flags_out, output, 4 bits: registered CCR {V,C,N,Z}, fed to the ALU old_flags input.
REQ-011 SHALL have port jmp_taken, output, 1 bit: combinational; equals jmp_valid AND the selected bit of flags_out.
REQ-012 SHALL have port stack_full, output, 1 bit: the shadow stack holds STACK_DEPTH entries.
REQ-013 SHALL have port stack_empty, output, 1 bit: the shadow stack holds 0 entries.
REQ-014 SHALL have port err, output, 1 bit: registered one-cycle pulse flagging an illegal request.

Function
REQ-015 SHALL update flags_out one cycle after a write request; there is no same-cycle bypass.
REQ-016 SHALL, when flags_we=1 and no higher-priority event occurs, load flags_in into the CCR.
REQ-017 SHALL, when jmp_taken=1, clear the tested flag bit next cycle; this clear overrides flags_in for that bit only when flags_we is also asserted.
REQ-018 SHALL, on a legal rti_restore (stack not empty), load the CCR from the top entry and decrement the depth; the popped value overrides both flags_we and the jump clear.
REQ-019 SHALL, on a legal int_save (stack not full), push the pre-edge flags_out value and increment the depth; flags_we and the jump clear still update the CCR that cycle.
REQ-020 SHALL treat an int_save while full as illegal: no push, depth and entries unchanged, err=1 next cycle.
REQ-021 SHALL treat an rti_restore while empty as illegal: the CCR takes the flags_we/jump-clear update only, err=1 next cycle.
REQ-022 SHALL treat int_save and rti_restore asserted together as illegal: the stack is unchanged, the restore is not applied, the flags_we/jump-clear update still happens, and err=1.
REQ-023 SHALL keep the depth counter within 0..STACK_DEPTH (no wrap); stack_full and stack_empty are decoded from the registered depth.
REQ-024 SHALL drive err=0 in every cycle not following an illegal request.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, set the CCR to 4'b0000, the depth to 0 (stack_empty=1, stack_full=0), and err to 0, overriding every other request that cycle.
REQ-026 SHALL leave the stack entry contents undefined after reset; they are unobservable because depth=0.
REQ-027 SHALL, with a reset mid-sequence (e.g. after a save), discard all pending nesting state.

Structure
REQ-028 SHALL take the flag bit indices (V=3, C=2, N=1, Z=0), the jmp_sel encodings and the default STACK_DEPTH from the shared defines package used by the ALU.
REQ-029 SHALL implement the shadow stack as one sub-module, flag_stack: a parameterised LIFO with push, pop, top, full and empty; ccr_unit owns the priority logic and err.

Verification
REQ-030 SHALL cover this scenario: flags_we=1 with flags_in=4'b0101 -> flags_out=4'b0101 the next cycle, not the same cycle.
REQ-031 SHALL cover this scenario: CCR=4'b0100, jmp_valid=1, jmp_sel=10 -> jmp_taken=1 combinationally, CCR=4'b0000 next cycle; the same with jmp_sel=00 -> jmp_taken=0 and CCR unchanged.
REQ-032 SHALL cover this scenario: CCR=4'b1001, then int_save, then flags_we with 4'b0010, then rti_restore -> CCR sequence 1001, 0010, 1001, with stack_empty back to 1.
REQ-033 SHALL cover this scenario: two int_save pulses (stack_full=1), then a third int_save -> err=1 for one cycle, depth stays 2, and two RTIs restore the values in LIFO order.
REQ-034 SHALL cover this scenario: rti_restore on an empty stack with flags_we=1 and flags_in=4'b1000 -> CCR=4'b1000 and err=1; int_save together with rti_restore -> err=1 and depth unchanged.
REQ-035 SHALL cover this scenario: rst asserted in the same cycle as flags_we=1 and int_save=1 -> CCR=0, depth=0 and err=0 next cycle.
